// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared defaults and types for the FIFO read-side drain controller.
// The skid-buffer occupancy encoding is shared by the buffer and the pop-issue logic.
package fifo_drain_ctrl_pkg;

    localparam int unsigned WIDTH_DEF     = 8;
    localparam int unsigned FRAME_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // The frame counter needs at least one bit, even when every word closes a frame.
    function automatic int unsigned frame_cnt_w(input int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_skid_buf2.sv
// Two-entry {data,last} output buffer; the head entry drives the stream directly.
// A push and a pop may share a cycle whenever the buffer is non-empty.
module fifo_drain_ctrl_skid_buf2
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       occ
);

    occ_t             occ_q;
    logic [WIDTH-1:0] head_data_q;
    logic             head_last_q;
    logic [WIDTH-1:0] tail_data_q;
    logic             tail_last_q;

    // NOTE: state uses <= so every register sees pre-edge values whatever the statement order;
    // the data registers are reset too so the stream data port reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q       <= OCC_EMPTY;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_data_q <= push_data;
                        head_last_q <= push_last;
                        occ_q       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_data_q <= push_data;
                        head_last_q <= push_last;
                    end else if (push) begin
                        tail_data_q <= push_data;
                        tail_last_q <= push_last;
                        occ_q       <= OCC_FULL;
                    end else if (pop) begin
                        occ_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                        if (push) begin
                            tail_data_q <= push_data;
                            tail_last_q <= push_last;
                        end else begin
                            occ_q <= OCC_ONE;
                        end
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    // The issue logic never lets a third word arrive while both entries are held.
    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && occ_q == OCC_FULL));

    assign head_data = head_data_q;
    assign head_last = head_last_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the synchronous FIFO: issues pops, absorbs the one-cycle read
// latency in a two-entry buffer and presents a bubble-free valid/ready stream with framing.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_rd_error_i,
    output logic             fifo_rd_en_o,
    input  logic             en_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             proto_err_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int unsigned     FC_W    = frame_cnt_w(FRAME_LEN);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

    logic            inflight_q;
    logic [FC_W-1:0] frame_cnt_q;
    logic            frame_last;
    logic [1:0]      occ;
    logic            pop_out;
    logic            room;

    assign pop_out    = m_valid_o & m_ready_i;
    assign frame_last = (frame_cnt_q == FC_LAST);

    // Room means buffered plus in-flight words stay below two; a same-cycle pop frees a slot.
    assign room         = (occ == OCC_EMPTY) | ((occ == OCC_ONE) & ~inflight_q);
    assign fifo_rd_en_o = en_i & ~fifo_empty_i & ~rst_i & (room | pop_out);

    assign m_valid_o = (occ != OCC_EMPTY);
    assign busy_o    = m_valid_o | inflight_q;

    fifo_drain_ctrl_skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (inflight_q),
        .push_data (fifo_rdata_i),
        .push_last (frame_last),
        .pop       (pop_out),
        .head_data (m_data_o),
        .head_last (m_last_o),
        .occ       (occ)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q  <= 1'b0;
            frame_cnt_q <= '0;
            word_cnt_o  <= '0;
            proto_err_o <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            if (inflight_q) begin
                frame_cnt_q <= frame_last ? '0 : frame_cnt_q + FC_W'(1);
            end
            if (pop_out) begin
                word_cnt_o <= word_cnt_o + CNT_W'(1);
            end
            if (fifo_rd_error_i) begin
                proto_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO with registered read data, a per-cycle vector table,
// directed multi-cycle sequences and a randomized run scored against an in-order word queue.
module tb_fifo_drain_ctrl;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             fifo_rd_error;
    logic             fifo_rd_en;
    logic             en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic             proto_err;
    logic [CNT_W-1:0] word_cnt;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem [256];
    logic [7:0]       wr_ptr;
    logic [7:0]       rd_ptr;
    logic [7:0]       fifo_count;

    int               n_vec;
    int               n_fail;
    logic [WIDTH-1:0] exp_q [$];
    int               acc_cnt;
    logic             stall_prev;
    logic [WIDTH:0]   prev_head;

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] wdata;
        logic             en;
        logic             rdy;
        logic             rd_en;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             last;
        logic             busy;
        logic [CNT_W-1:0] wcnt;
    } vec_t;

    vec_t tbl [13];

    fifo_drain_ctrl #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fifo_rdata_i    (fifo_rdata),
        .fifo_empty_i    (fifo_empty),
        .fifo_rd_error_i (fifo_rd_error),
        .fifo_rd_en_o    (fifo_rd_en),
        .en_i            (en),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_last_o        (m_last),
        .busy_o          (busy),
        .proto_err_o     (proto_err),
        .word_cnt_o      (word_cnt)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural synchronous FIFO: empty is combinational, read data appears the cycle after a pop.
    always @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 8'd1;
            end
            if (fifo_rd_en) begin
                fifo_rdata <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 8'd1;
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_count = wr_ptr - rd_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard, evaluated mid-cycle: words leave in write order, every FRAME_LEN-th word since
    // reset is last, the word counter equals the number already accepted, stalled heads hold.
    task automatic monitor();
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        if (rst_i) begin
            exp_q.delete();
            acc_cnt    = 0;
            stall_prev = 1'b0;
            return;
        end
        if (fifo_rd_en) check("rd_en_when_empty", 32'(fifo_empty), 32'd0);
        if (stall_prev) check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_head}));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL accept_extra: got word 0x%0h, expected no word (t=%0t)", m_data, $time);
            end else begin
                exp_d = exp_q.pop_front();
                exp_l = ((acc_cnt % FRAME_LEN) == FRAME_LEN - 1);
                check("accept", 32'({word_cnt, m_last, m_data}), 32'({CNT_W'(acc_cnt), exp_l, exp_d}));
            end
            acc_cnt++;
        end
        stall_prev = m_valid && !m_ready;
        prev_head  = {m_last, m_data};
        if (wr_en) exp_q.push_back(wr_data);
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc();
        step();
        adv();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        wr_en = 1'b0;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic wait_drained(input int max_cyc, input string name);
        logic done;
        done    = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        wr_en   = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            step();
            if (fifo_empty && !busy) done = 1'b1;
            adv();
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        int fall_cyc;
        int first_v;
        int last_v;
        int n_valid;
        int pops;
        logic [15:0] act;
        logic [15:0] exp;

        n_vec = 0;  n_fail = 0;  acc_cnt = 0;  stall_prev = 1'b0;  prev_head = '0;
        rst_i = 1'b1;  wr_en = 1'b0;  wr_data = '0;  en = 1'b0;  m_ready = 1'b0;  fifo_rd_error = 1'b0;

        //               wr    wdata  en    rdy  | rd_en valid  data   last  busy  wcnt
        tbl[0]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd0};
        tbl[4]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd0};
        tbl[7]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 4'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 4'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 4'd3};

        // Reset state
        cyc();
        cyc();
        rst_i = 1'b0;
        step();
        check("reset_state", 32'({fifo_rd_en, m_valid, m_data, m_last, busy, proto_err, word_cnt}), 32'd0);
        adv();

        // Cycle-exact vector table (stall, refill, en drop, frame close)
        do_reset();
        for (int i = 0; i < 13; i++) begin
            wr_en = tbl[i].wr;  wr_data = tbl[i].wdata;  en = tbl[i].en;  m_ready = tbl[i].rdy;
            step();
            act = {fifo_rd_en, m_valid, tbl[i].valid ? {m_last, m_data} : 9'h0, busy, word_cnt};
            exp = {tbl[i].rd_en, tbl[i].valid, tbl[i].valid ? {tbl[i].last, tbl[i].data} : 9'h0,
                   tbl[i].busy, tbl[i].wcnt};
            check($sformatf("tbl[%0d]", i), 32'(act), 32'(exp));
            adv();
        end

        // Full-throughput burst: two-cycle latency, eight back-to-back words
        do_reset();
        en = 1'b1;  m_ready = 1'b1;
        fall_cyc = -1;  first_v = -1;  last_v = -1;  n_valid = 0;
        for (int c = 0; c < 20; c++) begin
            wr_en = (c < 8);  wr_data = 8'h11 + 8'(c);
            step();
            if (!fifo_empty && fall_cyc < 0) fall_cyc = c;
            if (m_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                n_valid++;
            end
            adv();
        end
        check("burst_latency", 32'(first_v - fall_cyc), 32'd2);
        check("burst_no_bubble", 32'({8'(last_v - first_v + 1), 8'(n_valid)}), 32'({8'd8, 8'd8}));
        step();
        check("burst_end", 32'({busy, word_cnt}), 32'({1'b0, 4'd8}));
        adv();

        // Alternating ready
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wr_en = (c < 8);  wr_data = 8'h21 + 8'(c);  m_ready = (c % 2 == 0);
            cyc();
        end
        step();
        check("toggle_end", 32'({busy, word_cnt, 8'(exp_q.size())}), 32'({1'b0, 4'd8, 8'd0}));
        adv();

        // Backpressure: only two pops may be outstanding into the buffer
        do_reset();
        en = 1'b0;  m_ready = 1'b0;  pops = 0;
        for (int c = 0; c < 16; c++) begin
            wr_en = 1'b1;  wr_data = 8'h30 + 8'(c);
            step();
            if (fifo_rd_en) pops++;
            adv();
        end
        wr_en = 1'b0;  en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (fifo_rd_en) pops++;
            adv();
        end
        step();
        if (fifo_rd_en) pops++;
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_head", 32'({m_valid, m_data}), 32'({1'b1, 8'h30}));
        adv();
        wait_drained(60, "bp_drain");
        check("bp_word_cnt", 32'(word_cnt), 32'(CNT_W'(16)));

        // en dropped right after the third pop is issued
        do_reset();
        en = 1'b0;  m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            wr_en = 1'b1;  wr_data = 8'h41 + 8'(c);
            cyc();
        end
        wr_en = 1'b0;  en = 1'b1;  pops = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (fifo_rd_en) pops++;
            adv();
            if (pops == 3) en = 1'b0;
        end
        step();
        check("en_drop", 32'({8'(pops), 8'(acc_cnt), word_cnt, busy, fifo_count}),
              32'({8'd3, 8'd3, 4'd3, 1'b0, 8'd5}));
        adv();

        // Reset with one word buffered and one in flight
        do_reset();
        en = 1'b1;  m_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            wr_en = (c < 4);  wr_data = 8'h50 + 8'(c);
            cyc();
        end
        wr_en = 1'b0;  m_ready = 1'b1;
        cyc();
        rst_i = 1'b1;
        step();
        check("rst_blocks_rd_en", 32'(fifo_rd_en), 32'd0);
        adv();
        rst_i = 1'b0;
        step();
        check("rst_clears", 32'({m_valid, busy, word_cnt}), 32'd0);
        adv();
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1;  wr_data = 8'h61 + 8'(c);
            cyc();
        end
        wait_drained(20, "rst_refill_drain");
        check("rst_refill_cnt", 32'(word_cnt), 32'd4);

        // Sticky protocol error
        do_reset();
        fifo_rd_error = 1'b1;
        cyc();
        fifo_rd_error = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("proto_sticky[%0d]", c), 32'(proto_err), 32'd1);
            adv();
        end
        do_reset();
        step();
        check("proto_cleared", 32'(proto_err), 32'd0);
        adv();

        // Randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst_i   = ($urandom_range(249) == 0);
            wr_en   = (fifo_count < 8'd200) && ($urandom_range(9) < 6);
            wr_data = 8'($urandom);
            en      = ($urandom_range(9) != 0);
            m_ready = ($urandom_range(9) < 6);
            cyc();
        end
        rst_i = 1'b0;
        wait_drained(400, "rand_drain");
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
